// File: rtl/cyl_result_serializer.sv
// cyl_result_serializer: sends each {r,theta},z result as two 8N1 bytes on tx, with a one-entry holding register
module cyl_result_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] r,
  input  logic [3:0] theta,
  input  logic [7:0] z,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic hold_full, hold_full_n, byte_idx, byte_idx_n, tx_n, done_n, bit_end, load;
  logic [15:0] hold, hold_n;
  logic [7:0] shift, shift_n, byte1, byte1_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [BW-1:0] baud, baud_n;
  assign in_ready = ~hold_full;
  assign busy = state != IDLE;
  assign bit_end = baud == LAST;
  // a pending result loads from IDLE or straight after the last stop bit, giving gapless frames
  assign load = ena && hold_full && (state == IDLE || (state == STOP && bit_end && byte_idx));
  always_comb begin
    state_n = state;
    hold_full_n = hold_full;
    hold_n = hold;
    shift_n = shift;
    byte1_n = byte1;
    byte_idx_n = byte_idx;
    bit_cnt_n = bit_cnt;
    baud_n = baud;
    tx_n = tx;
    done_n = 1'b0;
    if (ena) begin
      if (in_valid && !hold_full) begin
        hold_full_n = 1'b1;
        hold_n = {r, theta, z};
      end
      if (state != IDLE) baud_n = bit_end ? '0 : baud + 1'b1;
      case (state)
        START: if (bit_end) begin
          state_n = DATA;
          bit_cnt_n = '0;
          tx_n = shift[0];
        end
        DATA: if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n = 1'b1;
          end else begin
            shift_n = shift >> 1;
            tx_n = shift[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        STOP: if (bit_end) begin
          if (!byte_idx) begin
            state_n = START;
            shift_n = byte1;
            byte_idx_n = 1'b1;
            tx_n = 1'b0;
          end else begin
            done_n = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      if (load) begin
        shift_n = hold[15:8];
        byte1_n = hold[7:0];
        hold_full_n = 1'b0;
        byte_idx_n = 1'b0;
        state_n = START;
        tx_n = 1'b0;
        baud_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_full <= 1'b0;
      hold <= '0;
      shift <= '0;
      byte1 <= '0;
      byte_idx <= 1'b0;
      bit_cnt <= '0;
      baud <= '0;
      tx <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      hold_full <= hold_full_n;
      hold <= hold_n;
      shift <= shift_n;
      byte1 <= byte1_n;
      byte_idx <= byte_idx_n;
      bit_cnt <= bit_cnt_n;
      baud <= baud_n;
      tx <= tx_n;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_cyl_result_serializer.sv
// tb_cyl_result_serializer: scoreboard bench decoding tx frames against accepted results
module tb_cyl_result_serializer;
  localparam int CPB = 4;
  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b1, in_valid = 1'b0;
  logic [3:0] r = '0, theta = '0;
  logic [7:0] z = '0;
  logic in_ready, tx, busy, frame_done;
  int n_checks = 0, n_fail = 0;
  int acc_cnt = 0, frames = 0, fd_cnt = 0, last_raw = 0, contig = 0, cyc = 0;
  int p = 0, raw = 0;
  logic act = 1'b0, ena_e = 1'b1;
  logic [19:0] bits = '0;
  logic [15:0] q[$];

  cyl_result_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .theta(theta), .z(z), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    ena_e <= ena;
    if (rst_n && ena && in_valid && in_ready) begin
      q.push_back({r, theta, z});
      acc_cnt++;
    end
  end

  // receiver: p counts enabled edges since the start bit appeared, so stalls stretch bits transparently
  always @(negedge clk) begin
    logic fd_exp;
    fd_exp = 1'b0;
    if (!rst_n) act = 1'b0;
    else if (act) begin
      raw++;
      if (ena_e) begin
        p++;
        if (p < 20*CPB && p % CPB == CPB/2) bits[p/CPB] = tx;
        if (p == 20*CPB) begin
          fd_exp = 1'b1;
          frames++;
          last_raw = raw;
          check("framing", {bits[0], bits[9], bits[10], bits[19]}, 4'b0101);
          check("frame_done", frame_done, 1);
          if (q.size() == 0) check("unexpected_frame", 1, 0);
          else check("frame_data", {bits[8:1], bits[18:11]}, q.pop_front());
          if (!tx) begin
            p = 0;
            contig++;
          end else act = 1'b0;
        end
      end
    end else if (!tx) begin
      act = 1'b1;
      p = 0;
      raw = 0;
    end
    if (frame_done) fd_cnt++;
    if (frame_done && !fd_exp) check("spurious_frame_done", frame_done, 0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] rr, input logic [3:0] tt, input logic [7:0] zz, input bit keep);
    int n0;
    n0 = acc_cnt;
    r = rr;
    theta = tt;
    z = zz;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && acc_cnt == n0; i++) tick(1);
    if (acc_cnt == n0) check("accept_timeout", 0, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 2000 && frames < target; i++) @(negedge clk);
    if (frames < target) check("frame_timeout", frames, target);
  endtask

  initial begin
    int f0, c0, a0, d0, t2;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    f0 = frames;
    send(4'd5, 4'd3, 8'd50, 1'b0);
    check("ready_low_after_accept", in_ready, 0);
    tick(1);
    check("ready_after_load", in_ready, 1);
    check("tx_start", tx, 0);
    check("busy_start", busy, 1);
    wait_frames(f0 + 1);
    check("single_len", last_raw, 80);
    check("busy_after_frame", busy, 0);
    tick(2);
    f0 = frames;
    c0 = contig;
    send(4'd3, 4'd4, 8'd4, 1'b1);
    send(4'd5, 4'd1, 8'd100, 1'b1);
    t2 = cyc;
    tick(5);
    check("stall_ready", in_ready, 0);
    send(4'hC, 4'd2, 8'd30, 1'b0);
    check("third_wait", cyc - t2, 80);
    wait_frames(f0 + 3);
    check("burst_len", last_raw, 240);
    check("contiguous", contig - c0, 2);
    tick(2);
    f0 = frames;
    send(4'd9, 4'd6, 8'hA5, 1'b0);
    tick(15);
    a0 = acc_cnt;
    r = 4'd1;
    theta = 4'd1;
    z = 8'd1;
    in_valid = 1'b1;
    ena = 1'b0;
    tick(7);
    in_valid = 1'b0;
    ena = 1'b1;
    check("no_accept_disabled", acc_cnt, a0);
    wait_frames(f0 + 1);
    check("stall_len", last_raw, 87);
    tick(2);
    f0 = frames;
    d0 = fd_cnt;
    send(4'd1, 4'd2, 8'd3, 1'b0);
    send(4'd4, 4'd5, 8'd6, 1'b0);
    tick(55);
    check("pending_before_rst", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    q.delete();
    #10 rst_n = 1'b1;
    tick(200);
    check("rst_no_frame", frames, f0);
    check("rst_no_frame_done", fd_cnt, d0);
    check("rst_ready", in_ready, 1);
    tick(2);
    f0 = frames;
    send(4'd7, 4'd8, 8'h3C, 1'b0);
    a0 = acc_cnt;
    r = 4'hA;
    theta = 4'hB;
    z = 8'hE1;
    in_valid = 1'b1;
    tick(1);
    check("drain_not_accepted", acc_cnt, a0);
    check("drain_ready", in_ready, 1);
    tick(1);
    check("drain_accepted_next", acc_cnt, a0 + 1);
    in_valid = 1'b0;
    wait_frames(f0 + 2);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
